// File: rtl/spi_req_arbiter_if.sv
// Bus bundle between register-access requesters, spi_req_arbiter and SPI_MASTER.
// slave = arbiter view; master = requesters plus SPI_MASTER view.
interface spi_req_arbiter_if #(
    parameter int unsigned N = 4,
    parameter int unsigned D = 8,
    parameter int unsigned A = 4
);
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_rd;
    logic [N*A-1:0] req_addr;
    logic [N*D-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   rsp_valid;
    logic [D-1:0]   rsp_data;
    logic           rsp_err;
    logic           m_wr;
    logic           m_rd;
    logic [A-1:0]   m_addr;
    logic [D-1:0]   m_datai;
    logic [D-1:0]   m_datao;
    logic           m_busy;

    modport slave (
        input  req_valid, req_rd, req_addr, req_data, m_datao, m_busy,
        output req_ready, rsp_valid, rsp_data, rsp_err, m_wr, m_rd, m_addr, m_datai
    );

    modport master (
        output req_valid, req_rd, req_addr, req_data, m_datao, m_busy,
        input  req_ready, rsp_valid, rsp_data, rsp_err, m_wr, m_rd, m_addr, m_datai
    );
endinterface

// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter sharing one SPI_MASTER between N register-access requesters.
// Optional watchdog enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_req_arbiter #(
    parameter int unsigned N      = 4,
    parameter int unsigned D      = 8,
    parameter int unsigned A      = 4,
    parameter int unsigned TO_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    spi_req_arbiter_if.slave  bus
);
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    if (N < 1 || TO_CYC < 2) begin : g_param_chk
        $error("spi_req_arbiter: N must be >= 1 and TO_CYC >= 2");
    end

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        RESP      = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] gnt_q, gnt_d;
    logic          rd_q, rd_d;
    logic [A-1:0]  addr_q, addr_d;
    logic [D-1:0]  data_q, data_d;
    logic [D-1:0]  rsp_data_q, rsp_data_d;
    logic [N-1:0]  req_ready_q, req_ready_d;
    logic [N-1:0]  rsp_valid_q, rsp_valid_d;
    logic          m_wr_q, m_wr_d;
    logic          m_rd_q, m_rd_d;

    logic [IW-1:0] pick;
    logic [N-1:0]  rd_sh;
    logic [A-1:0]  sel_addr;
    logic [D-1:0]  sel_data;

    // First requester at or after the pointer, wrapping around.
    function automatic logic [IW-1:0] rr_pick(input logic [N-1:0] v, input logic [IW-1:0] p);
        logic [IW-1:0] r;
        logic          hit;
        logic [N-1:0]  sh;
        int unsigned   j;
        r   = '0;
        hit = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            j  = (32'(p) + k) % N;
            sh = v >> j;
            if (!hit && sh[0]) begin
                r   = IW'(j);
                hit = 1'b1;
            end
        end
        return r;
    endfunction

    always_comb pick = rr_pick(bus.req_valid, ptr_q);

    assign rd_sh    = bus.req_rd >> pick;
    assign sel_addr = A'(bus.req_addr >> (32'(pick) * A));
    assign sel_data = D'(bus.req_data >> (32'(pick) * D));

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TO_CYC + 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            rsp_err_q, rsp_err_d;
`endif

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        rd_d        = rd_q;
        addr_d      = addr_q;
        data_d      = data_q;
        rsp_data_d  = rsp_data_q;
        req_ready_d = '0;
        rsp_valid_d = '0;
        m_wr_d      = 1'b0;
        m_rd_d      = 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
        wd_d        = wd_q;
        rsp_err_d   = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                // Busy master (e.g. left running by reset/timeout) blocks new grants.
                if (!bus.m_busy && (|bus.req_valid)) begin
                    gnt_d       = pick;
                    rd_d        = rd_sh[0];
                    addr_d      = sel_addr;
                    data_d      = sel_data;
                    req_ready_d = N'(1) << pick;
                    m_rd_d      = rd_sh[0];
                    m_wr_d      = !rd_sh[0];
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (bus.m_busy) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (!bus.m_busy) begin
                    state_d     = RESP;
                    rsp_valid_d = N'(1) << gnt_q;
                    rsp_data_d  = rd_q ? bus.m_datao : '0;
                end
            end
            RESP: begin
                state_d = IDLE;
                ptr_d   = IW'((32'(gnt_q) + 1) % N);
                rd_d    = 1'b0;
                addr_d  = '0;
                data_d  = '0;
            end
            default: state_d = IDLE;
        endcase
`ifdef SPI_ARB_TIMEOUT_EN
        // Watchdog: RESP lands exactly TO_CYC cycles after ISSUE.
        if (state_q == ISSUE) begin
            wd_d = '0;
        end else if (state_q == WAIT_BUSY || state_q == WAIT_DONE) begin
            wd_d = wd_q + 1'b1;
            if (wd_q == WD_W'(TO_CYC - 2)) begin
                state_d     = RESP;
                rsp_valid_d = N'(1) << gnt_q;
                rsp_data_d  = '0;
                rsp_err_d   = 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            gnt_q       <= '0;
            rd_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            rsp_data_q  <= '0;
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            m_wr_q      <= 1'b0;
            m_rd_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            rd_q        <= rd_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            rsp_data_q  <= rsp_data_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            m_wr_q      <= m_wr_d;
            m_rd_q      <= m_rd_d;
        end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q      <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    assign bus.rsp_err = rsp_err_q;
`else
    assign bus.rsp_err = 1'b0;
`endif

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.m_wr      = m_wr_q;
    assign bus.m_rd      = m_rd_q;
    assign bus.m_addr    = addr_q;
    assign bus.m_datai   = data_q;

endmodule
